// File: rtl/mmio_responder.sv
// mmio_responder: CPU memory-port responder with RAM window,
// compare timer (MMIO_TIMER_EN) and console transmit FIFO.
module mmio_responder #(
   parameter int RAM_ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int TMR_PRESCALE   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rw,
   input  logic [15:0] addr,
   input  logic [7:0]  data,
   output logic [7:0]  q,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int RAM_SIZE = 1 << RAM_ADDR_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

   localparam logic [15:0] A_CNT  = 16'hFF00;
   localparam logic [15:0] A_CMP  = 16'hFF01;
   localparam logic [15:0] A_CTRL = 16'hFF02;
   localparam logic [15:0] A_STAT = 16'hFF03;
   localparam logic [15:0] A_TX   = 16'hFF04;

   logic        prev_rw;
   logic [15:0] prev_addr;
   logic        wr_first;
   logic        ram_sel;
   logic [RAM_ADDR_WIDTH-1:0] ram_idx;
   logic [7:0]  ram [RAM_SIZE];
   logic [7:0]  rd_val;
   logic [7:0]  status;
   logic        ctrl_wr;

   logic [7:0]  fifo [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0] count;
   logic        full;
   logic        empty;
   logic        pop;
   logic        push_req;
   logic        push_ok;
   logic        ovf;

   logic        tmr_en;
   logic        tmr_hit;

   // CPU holds a write for two cycles; only the first one acts
   assign wr_first = rw && (!prev_rw || (prev_addr != addr));
   assign ram_sel  = (addr >> RAM_ADDR_WIDTH) == 16'd0;
   assign ram_idx  = addr[RAM_ADDR_WIDTH-1:0];
   assign ctrl_wr  = wr_first && (addr == A_CTRL);

   // Track the previous strobe to detect the start of a write run
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_rw   <= 1'b0;
         prev_addr <= 16'h0000;
      end else begin
         prev_rw   <= rw;
         prev_addr <= addr;
      end
   end

   // RAM window storage, contents not reset
   always_ff @(posedge clk) begin
      if (wr_first && ram_sel)
         ram[ram_idx] <= data;
   end

`ifdef MMIO_TIMER_EN
   localparam int PW = (TMR_PRESCALE > 1) ? $clog2(TMR_PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TMR_PRESCALE - 1);

   logic [PW-1:0] pre;
   logic [7:0]    cnt;
   logic [7:0]    cmp;
   logic          tick;
   logic          match;

   assign tick  = tmr_en && (pre == PRE_LAST);
   assign match = tick && (cnt == cmp);

   // Prescaler, counter, compare and hit flag; CNT writes beat ticks
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre     <= '0;
         cnt     <= 8'h00;
         cmp     <= 8'h00;
         tmr_en  <= 1'b0;
         tmr_hit <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            tmr_en <= data[0];
            pre    <= '0;
         end else if (tmr_en) begin
            pre <= tick ? '0 : pre + 1'b1;
         end
         if (wr_first && (addr == A_CMP))
            cmp <= data;
         if (wr_first && (addr == A_CNT))
            cnt <= data;
         else if (match)
            cnt <= 8'h00;
         else if (tick)
            cnt <= cnt + 8'h01;
         if (match)
            tmr_hit <= 1'b1;
         else if (ctrl_wr && data[1])
            tmr_hit <= 1'b0;
      end
   end
`else
   assign tmr_en  = 1'b0;
   assign tmr_hit = 1'b0;
`endif

   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : fifo[rptr];
   assign pop      = tx_valid && tx_ready;
   assign push_req = wr_first && (addr == A_TX);
   assign push_ok  = push_req && (!full || pop);

   // FIFO storage, only entries between rptr and wptr are meaningful
   always_ff @(posedge clk) begin
      if (push_ok)
         fifo[wptr] <= data;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push_ok)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
         if (push_req && !push_ok)
            ovf <= 1'b1;
         else if (ctrl_wr && data[2])
            ovf <= 1'b0;
      end
   end

   assign status = {3'b000, tmr_en, ovf, empty, full, tmr_hit};

   // Read mux over pre-edge state
   always_comb begin
      rd_val = 8'h00;
      if (ram_sel) begin
         rd_val = ram[ram_idx];
      end else begin
         case (addr)
`ifdef MMIO_TIMER_EN
            A_CNT:   rd_val = cnt;
            A_CMP:   rd_val = cmp;
`endif
            A_STAT:  rd_val = status;
            default: rd_val = 8'h00;
         endcase
      end
   end

   // Registered read data, one cycle latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= 8'h00;
      else
         q <= rd_val;
   end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed checks of RAM, write qualification,
// FIFO flow, timer and asynchronous reset.
module tb_mmio_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        rw;
   logic [15:0] addr;
   logic [7:0]  data;
   logic [7:0]  q;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int ncmp  = 0;
   int nfail = 0;

   logic [7:0] exp4 [4];

   mmio_responder dut (
      .clk      (clk),
      .rst      (rst),
      .rw       (rw),
      .addr     (addr),
      .data     (data),
      .q        (q),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
      end
   endtask

   task automatic cyc(input logic r, input logic [15:0] a,
                      input logic [7:0] d);
      rw   = r;
      addr = a;
      data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      cyc(1'b1, a, d);
      cyc(1'b1, a, d);
      cyc(1'b0, 16'h0000, 8'h00);
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] expv,
                     input string tag);
      cyc(1'b0, a, 8'h00);
      chk(tag, q, expv);
   endtask

   initial begin
      rst      = 1'b0;
      rw       = 1'b0;
      addr     = 16'h0000;
      data     = 8'h00;
      tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", q, 8'h00);
      chk("rst_valid", {7'b0, tx_valid}, 8'h00);
      chk("rst_txdata", tx_data, 8'h00);
      rst = 1'b1;
      rd(16'hFF03, 8'h04, "status_reset");

      // RAM round trip and unmapped reads
      wr(16'h0010, 8'hA5);
      rd(16'h0010, 8'hA5, "ram_rt");
      rd(16'h0100, 8'h00, "unmapped");
      rd(16'hFF04, 8'h00, "txdata_rd");

      // Two-cycle write pushes exactly one entry
      cyc(1'b1, 16'hFF04, 8'h41);
      chk("wq_valid", {7'b0, tx_valid}, 8'h01);
      chk("wq_data", tx_data, 8'h41);
      cyc(1'b1, 16'hFF04, 8'h41);
      cyc(1'b0, 16'h0000, 8'h00);
      rd(16'hFF03, 8'h00, "wq_status");
      tx_ready = 1'b1;
      cyc(1'b0, 16'h0000, 8'h00);
      tx_ready = 1'b0;
      chk("wq_one", {7'b0, tx_valid}, 8'h00);

      // Fill, overflow, drain
      for (int i = 1; i <= 5; i++)
         wr(16'hFF04, 8'(i));
      rd(16'hFF03, 8'h0A, "ovf_status");
      tx_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", {7'b0, tx_valid}, 8'h01);
         chk("drain_data", tx_data, 8'(i));
         cyc(1'b0, 16'h0000, 8'h00);
      end
      chk("drain_empty", {7'b0, tx_valid}, 8'h00);
      tx_ready = 1'b0;
      wr(16'hFF02, 8'h04);
      rd(16'hFF03, 8'h04, "ovf_clear");

      // Push into a full FIFO with a same-cycle pop
      for (int i = 0; i < 4; i++)
         wr(16'hFF04, 8'(8'h11 + i));
      chk("fp_head", tx_data, 8'h11);
      tx_ready = 1'b1;
      cyc(1'b1, 16'hFF04, 8'h77);
      tx_ready = 1'b0;
      chk("fp_pop", tx_data, 8'h12);
      cyc(1'b1, 16'hFF04, 8'h77);
      cyc(1'b0, 16'h0000, 8'h00);
      rd(16'hFF03, 8'h02, "fp_status");
      exp4[0] = 8'h12;
      exp4[1] = 8'h13;
      exp4[2] = 8'h14;
      exp4[3] = 8'h77;
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("fp_drain", tx_data, exp4[i]);
         cyc(1'b0, 16'h0000, 8'h00);
      end
      chk("fp_empty", {7'b0, tx_valid}, 8'h00);
      tx_ready = 1'b0;

`ifdef MMIO_TIMER_EN
      // Timer counts 1,2,3,0 with compare 3
      wr(16'hFF01, 8'h03);
      cyc(1'b1, 16'hFF02, 8'h01);
      cyc(1'b1, 16'hFF02, 8'h01);
      rd(16'hFF00, 8'h01, "cnt_1");
      rd(16'hFF00, 8'h02, "cnt_2");
      rd(16'hFF00, 8'h03, "cnt_3");
      rd(16'hFF00, 8'h00, "cnt_wrap");
      rd(16'hFF03, 8'h15, "tmr_hit");
      wr(16'hFF01, 8'h80);
      wr(16'hFF02, 8'h03);
      rd(16'hFF03, 8'h14, "hit_clear");
      wr(16'hFF00, 8'h10);
      rd(16'hFF00, 8'h12, "cnt_write");
      rd(16'hFF01, 8'h80, "cmp_read");
`else
      // Timer page behaves as unmapped
      wr(16'hFF00, 8'h55);
      rd(16'hFF00, 8'h00, "cnt_unmapped");
      wr(16'hFF01, 8'h03);
      rd(16'hFF01, 8'h00, "cmp_unmapped");
      wr(16'hFF02, 8'h03);
      rd(16'hFF03, 8'h04, "status_notmr");
`endif

      // Asynchronous reset with three entries queued
      wr(16'hFF04, 8'h21);
      wr(16'hFF04, 8'h22);
      wr(16'hFF04, 8'h23);
      chk("ar_valid_pre", {7'b0, tx_valid}, 8'h01);
      rd(16'h0010, 8'hA5, "ar_q_pre");
      #2;
      rst = 1'b0;
      #1;
      chk("ar_valid", {7'b0, tx_valid}, 8'h00);
      chk("ar_q", q, 8'h00);
      chk("ar_txdata", tx_data, 8'h00);
      #2;
      rst = 1'b1;
      rd(16'hFF03, 8'h04, "ar_status");
      rd(16'hFF00, 8'h00, "ar_cnt");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
